// File: rtl/bus_arbiter.sv
// Four-slot shared-RAM arbiter: slot 1 serves the owning bus master (CPU, blitter or DMA),
// slot 3 serves video fetch, and slots 0/2 leave the RAM idle.
module bus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  bus_cycle,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic [23:1] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        blt_br,
  output logic        blt_bg,
  input  logic [22:0] blt_addr,
  input  logic        blt_read,
  input  logic        blt_write,
  input  logic [15:0] blt_wdata,
  output logic [15:0] blt_rdata,
  input  logic        dma_req,
  output logic        dma_ack,
  input  logic [22:0] dma_addr,
  input  logic        dma_read,
  input  logic        dma_write,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  input  logic [22:0] video_addr,
  output logic [15:0] video_data,
  output logic [22:0] ram_addr,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [1:0]  ram_ds,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [1:0]  owner_state
);

  // Request/grant: a master holds blt_br/dma_req high while it wants the bus; the grant
  // (blt_bg/dma_ack) changes only at the frame boundary and persists for a whole frame.
  typedef enum logic [1:0] {OWN_CPU = 2'd0, OWN_BLT = 2'd1, OWN_DMA = 2'd2} owner_t;

  owner_t owner_q, owner_d;

  logic [22:0] m_addr,  ram_addr_d;
  logic        m_we,    ram_we_d;
  logic        m_oe,    ram_oe_d;
  logic [1:0]  m_ds,    ram_ds_d;
  logic [15:0] m_wdata, ram_wdata_d;

  assign owner_state = owner_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_cycle <= 2'd0;
      owner_q   <= OWN_CPU;
      blt_bg    <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      bus_cycle <= bus_cycle + 2'd1;
      owner_q   <= owner_d;
      blt_bg    <= (owner_d == OWN_BLT);
      dma_ack   <= (owner_d == OWN_DMA);
    end
  end

  always_comb begin
    owner_d = owner_q;
    if (bus_cycle == 2'd3) begin
      if (dma_req)     owner_d = OWN_DMA;
      else if (blt_br) owner_d = OWN_BLT;
      else             owner_d = OWN_CPU;
    end
  end

  // Access the owner would perform in the master slot; write beats read for BLT/DMA.
  always_comb begin
    m_addr  = cpu_addr;
    m_we    = cpu_req & cpu_we;
    m_oe    = cpu_req & ~cpu_we;
    m_ds    = cpu_req ? {~cpu_uds, ~cpu_lds} : 2'b00;
    m_wdata = cpu_wdata;
    case (owner_q)
      OWN_BLT: begin
        m_addr  = blt_addr;
        m_we    = blt_write;
        m_oe    = blt_read & ~blt_write;
        m_ds    = 2'b11;
        m_wdata = blt_wdata;
      end
      OWN_DMA: begin
        m_addr  = dma_addr;
        m_we    = dma_write;
        m_oe    = dma_read & ~dma_write;
        m_ds    = 2'b11;
        m_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  // RAM controls are registered, so they are computed one clock ahead of their slot.
  always_comb begin
    ram_addr_d  = 23'd0;
    ram_we_d    = 1'b0;
    ram_oe_d    = 1'b0;
    ram_ds_d    = 2'b00;
    ram_wdata_d = 16'd0;
    if (bus_cycle == 2'd0) begin
      ram_addr_d  = m_addr;
      ram_we_d    = m_we;
      ram_oe_d    = m_oe;
      ram_ds_d    = m_ds;
      ram_wdata_d = m_wdata;
    end else if (bus_cycle == 2'd2) begin
      ram_addr_d = video_addr;
      ram_oe_d   = 1'b1;
      ram_ds_d   = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_addr  <= 23'd0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_ds    <= 2'b00;
      ram_wdata <= 16'd0;
    end else begin
      ram_addr  <= ram_addr_d;
      ram_we    <= ram_we_d;
      ram_oe    <= ram_oe_d;
      ram_ds    <= ram_ds_d;
      ram_wdata <= ram_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_rdata  <= 16'd0;
      blt_rdata  <= 16'd0;
      dma_rdata  <= 16'd0;
      video_data <= 16'd0;
    end else begin
      if (bus_cycle == 2'd1 && ram_oe) begin
        case (owner_q)
          OWN_BLT: blt_rdata <= ram_rdata;
          OWN_DMA: dma_rdata <= ram_rdata;
          default: cpu_rdata <= ram_rdata;
        endcase
      end
      if (bus_cycle == 2'd3) video_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter; read data expectations flow through exp_q.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  bus_cycle;
  logic        cpu_req, cpu_we, cpu_uds, cpu_lds;
  logic [23:1] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        blt_br, blt_bg, blt_read, blt_write;
  logic [22:0] blt_addr;
  logic [15:0] blt_wdata, blt_rdata;
  logic        dma_req, dma_ack, dma_read, dma_write;
  logic [22:0] dma_addr;
  logic [15:0] dma_wdata, dma_rdata;
  logic [22:0] video_addr;
  logic [15:0] video_data;
  logic [22:0] ram_addr;
  logic        ram_we, ram_oe;
  logic [1:0]  ram_ds;
  logic [15:0] ram_wdata, ram_rdata;
  logic [1:0]  owner_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  bus_arbiter dut (
    .clk(clk), .reset_n(reset_n), .bus_cycle(bus_cycle),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .blt_br(blt_br), .blt_bg(blt_bg), .blt_addr(blt_addr), .blt_read(blt_read),
    .blt_write(blt_write), .blt_wdata(blt_wdata), .blt_rdata(blt_rdata),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_addr(dma_addr), .dma_read(dma_read),
    .dma_write(dma_write), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .video_addr(video_addr), .video_data(video_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_ds(ram_ds),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner_state(owner_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance at least one clock, then to the next negedge where bus_cycle == s.
  task automatic goto_slot(input logic [1:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_cycle !== s && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (bus_cycle !== s) check("slot_timeout", {30'd0, bus_cycle}, {30'd0, s});
  endtask

  task automatic check_ram(input string tag, input logic [22:0] a, input logic we,
                           input logic oe, input logic [1:0] ds, input logic [15:0] wd);
    check({tag, "_addr"},  {9'd0, ram_addr}, {9'd0, a});
    check({tag, "_we"},    {31'd0, ram_we}, {31'd0, we});
    check({tag, "_oe"},    {31'd0, ram_oe}, {31'd0, oe});
    check({tag, "_ds"},    {30'd0, ram_ds}, {30'd0, ds});
    check({tag, "_wdata"}, {16'd0, ram_wdata}, {16'd0, wd});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_oe"}, {31'd0, ram_oe}, 32'd0);
    check({tag, "_ds"}, {30'd0, ram_ds}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_ram(tag, 23'd0, 1'b0, 1'b0, 2'b00, 16'd0);
    check({tag, "_cycle"}, {30'd0, bus_cycle}, 32'd0);
    check({tag, "_bg"},    {31'd0, blt_bg}, 32'd0);
    check({tag, "_ack"},   {31'd0, dma_ack}, 32'd0);
    check({tag, "_crd"},   {16'd0, cpu_rdata}, 32'd0);
    check({tag, "_brd"},   {16'd0, blt_rdata}, 32'd0);
    check({tag, "_drd"},   {16'd0, dma_rdata}, 32'd0);
    check({tag, "_vid"},   {16'd0, video_data}, 32'd0);
  endtask

  task automatic pop_cmp(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {16'd0, obs}, {16'd0, e});
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [22:0] a;
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    cpu_addr = 23'h000100; cpu_wdata = 16'h0;
    blt_br = 1'b0; blt_addr = 23'h0; blt_read = 1'b0; blt_write = 1'b0; blt_wdata = 16'h0;
    dma_req = 1'b0; dma_addr = 23'h0; dma_read = 1'b0; dma_write = 1'b0; dma_wdata = 16'h0;
    video_addr = 23'h078000; ram_rdata = 16'h0;

    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset_n = 1'b1;

    // CPU read: strobe in slot 1, data valid after slot 1 ends
    goto_slot(1);
    check_ram("cpu_rd", 23'h000100, 1'b0, 1'b1, 2'b11, 16'h0);
    ram_rdata = 16'h1234;
    exp_q.push_back(16'h1234);
    goto_slot(2);
    check_idle("slot2");
    pop_cmp("cpu_rdata", cpu_rdata);

    // upper-byte CPU write
    cpu_we = 1'b1; cpu_uds = 1'b0; cpu_lds = 1'b1; cpu_wdata = 16'hBEEF;
    goto_slot(1);
    check_ram("cpu_wr", 23'h000100, 1'b1, 1'b0, 2'b10, 16'hBEEF);
    goto_slot(2);
    check_ram("cpu_wr_s2", 23'h0, 1'b0, 1'b0, 2'b00, 16'h0);
    check("cpu_rd_hold_wr", {16'd0, cpu_rdata}, 32'h1234);

    // video slot
    goto_slot(3);
    check_ram("video", 23'h078000, 1'b0, 1'b1, 2'b11, 16'h0);
    ram_rdata = 16'h5555;
    goto_slot(0);
    check("video_data", {16'd0, video_data}, 32'h5555);
    check("cpu_rd_hold_vid", {16'd0, cpu_rdata}, 32'h1234);
    check_idle("slot0");

    // no request -> idle master slot
    cpu_req = 1'b0;
    goto_slot(1);
    check_idle("cpu_idle");

    // blitter request raised in slot 1; CPU write attempt must be ignored
    blt_br = 1'b1; blt_write = 1'b1; blt_wdata = 16'hA5A5; blt_addr = 23'h012345;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h7FFFFF; cpu_wdata = 16'h1111;
    goto_slot(3);
    check("bg_mid_frame", {31'd0, blt_bg}, 32'd0);
    goto_slot(0);
    check("bg_granted", {31'd0, blt_bg}, 32'd1);
    check("ack_not", {31'd0, dma_ack}, 32'd0);
    goto_slot(1);
    check_ram("blt_wr", 23'h012345, 1'b1, 1'b0, 2'b11, 16'hA5A5);

    // read and write together: write wins
    blt_read = 1'b1;
    goto_slot(1);
    check_ram("blt_rw", 23'h012345, 1'b1, 1'b0, 2'b11, 16'hA5A5);
    blt_write = 1'b0;
    goto_slot(1);
    check_ram("blt_rd", 23'h012345, 1'b0, 1'b1, 2'b11, 16'hA5A5);
    ram_rdata = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    goto_slot(2);
    pop_cmp("blt_rdata", blt_rdata);
    check("cpu_rd_hold_blt", {16'd0, cpu_rdata}, 32'h1234);
    check("dma_rd_untouched", {16'd0, dma_rdata}, 32'h0);

    // DMA beats blitter
    dma_req = 1'b1; dma_read = 1'b1; dma_addr = 23'h400000; dma_wdata = 16'h2222;
    goto_slot(0);
    check("dma_ack", {31'd0, dma_ack}, 32'd1);
    check("bg_pre", {31'd0, blt_bg}, 32'd0);
    goto_slot(1);
    check_ram("dma_rd", 23'h400000, 1'b0, 1'b1, 2'b11, 16'h2222);
    ram_rdata = 16'hCAFE;
    exp_q.push_back(16'hCAFE);
    goto_slot(2);
    pop_cmp("dma_rdata", dma_rdata);
    check("blt_rd_hold", {16'd0, blt_rdata}, 32'h0F0F);
    dma_req = 1'b0;
    goto_slot(0);
    check("bg_after_dma", {31'd0, blt_bg}, 32'd1);
    check("ack_dropped", {31'd0, dma_ack}, 32'd0);

    // blitter releases: CPU back from the following frame; random CPU reads
    blt_br = 1'b0;
    goto_slot(0);
    check("bg_released", {31'd0, blt_bg}, 32'd0);
    cpu_we = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 23'($urandom_range(0, 32'h7FFFFF));
      d = 16'($urandom_range(0, 16'hFFFF));
      cpu_addr = a;
      goto_slot(1);
      check("rnd_addr", {9'd0, ram_addr}, {9'd0, a});
      check("rnd_oe", {31'd0, ram_oe}, 32'd1);
      ram_rdata = d;
      exp_q.push_back(d);
      goto_slot(2);
      pop_cmp("rnd_rdata", cpu_rdata);
      if (i < 5) goto_slot(0);
    end

    // reset during a blitter-owned master slot
    blt_br = 1'b1; blt_write = 1'b1; blt_read = 1'b0;
    goto_slot(0);
    check("bg_pre_rst", {31'd0, blt_bg}, 32'd1);
    goto_slot(1);
    check("blt_we_pre_rst", {31'd0, ram_we}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    cpu_addr = 23'h000200;
    reset_n = 1'b1;
    goto_slot(1);
    check("rel_addr_cpu", {9'd0, ram_addr}, 32'h000200);
    check("rel_oe", {31'd0, ram_oe}, 32'd1);
    check("rel_bg", {31'd0, blt_bg}, 32'd0);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
